// File: rtl/alu_program_sequencer.sv
// -----------------------------------------------------------------------------
// alu_program_sequencer
//
// Runs short command programs against the 8-register/ALU CPU core, so the host
// does not have to drive the core's command port on every cycle.
//
// How to use it:
//   1. While the block is idle, the host writes 16-bit instruction words into
//      a local program memory.
//   2. The host pulses start. The block then runs from address 0.
//   3. For each word it fetches, decodes, and issues a LOAD or OP command to
//      the core. It keeps the core's OP busy window and supports one counted
//      loop. It finishes on HALT, or when the program counter runs past the
//      last address.
//
// Instruction word (ir[15:14] selects the kind):
//   00 LOAD : opcode={ir[13:11],4'b0}, data_in=ir[7:0], load=1
//   01 OP   : opcode=ir[13:7], cin=ir[1], cout=ir[0]
//   10 CTRL : ir[13]=0 SETCNT cnt=ir[7:0]
//             ir[13]=1 DJNZ   cnt=cnt-1, jump to ir[ADDR_W-1:0] if new cnt!=0
//   11 HALT
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   prog_we_i/prog_addr_i/   program memory write port. Writes are accepted
//   prog_wdata_i             only while idle.
//   start_i                  1-cycle pulse that starts a run from address 0.
//                            Ignored while busy.
//   busy_o                   high from the cycle after start until the done
//                            cycle, inclusive
//   done_o                   1-cycle completion pulse (HALT or overrun)
//   err_o                    sticky overrun flag; cleared by the next start
//   cpu_data_in_o, cpu_opcode_o, cpu_cin_o, cpu_cout_o, cpu_load_o, cpu_ce_o
//                            registered command to the core. cpu_ce_o pulses
//                            for exactly one cycle per issued command.
//
// Reset clears all state and outputs. It does not clear the program memory.
// -----------------------------------------------------------------------------
module alu_program_sequencer #(
  parameter int ADDR_W = 5,
  parameter int OP_GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [15:0]       prog_wdata_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [7:0]        cpu_data_in_o,
  output logic [6:0]        cpu_opcode_o,
  output logic              cpu_cin_o,
  output logic              cpu_cout_o,
  output logic              cpu_load_o,
  output logic              cpu_ce_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int GAP_W = $clog2(OP_GAP + 2);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_GAP, S_DONE} state_e;
  typedef enum logic [1:0] {K_LOAD = 2'b00, K_OP = 2'b01, K_CTRL = 2'b10, K_HALT = 2'b11} kind_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [15:0]       ir_q, ir_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [7:0]        data_q, data_d;
  logic [6:0]        opcode_q, opcode_d;
  logic              cin_q, cin_d;
  logic              cout_q, cout_d;
  logic              load_q, load_d;
  logic              ce_q, ce_d;

  logic [15:0]       mem_q [DEPTH];

  // NOTE: the program memory has no reset. It must keep its contents across
  // rst, and leaving it out of the reset tree also lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (prog_we_i && state_q == S_IDLE) begin
      mem_q[prog_addr_i] <= prog_wdata_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the values from before the edge, whatever the statement
  // order is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      ir_q     <= '0;
      gap_q    <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      opcode_q <= '0;
      cin_q    <= 1'b0;
      cout_q   <= 1'b0;
      load_q   <= 1'b0;
      ce_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      ir_q     <= ir_d;
      gap_q    <= gap_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      data_q   <= data_d;
      opcode_q <= opcode_d;
      cin_q    <= cin_d;
      cout_q   <= cout_d;
      load_q   <= load_d;
      ce_q     <= ce_d;
    end
  end

  kind_e      kind;
  logic [7:0] cnt_dec;
  logic       jump;

  always_comb begin
    // NOTE: every signal gets a default before the case statement. No path
    // can then leave a signal unassigned, so no latch is inferred.
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    ir_d     = ir_q;
    gap_d    = gap_q;
    busy_d   = busy_q;
    err_d    = err_q;
    // Command fields default to 0, so every command lasts exactly one cycle.
    data_d   = '0;
    opcode_d = '0;
    cin_d    = 1'b0;
    cout_d   = 1'b0;
    load_d   = 1'b0;
    ce_d     = 1'b0;
    kind     = kind_e'(ir_q[15:14]);
    cnt_dec  = cnt_q - 8'd1;
    jump     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pc_d    = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        ir_d    = mem_q[pc_q];
        state_d = S_EXEC;
      end

      S_EXEC: begin
        pc_d = pc_q + ADDR_W'(1);
        case (kind)
          K_LOAD: begin
            opcode_d = {ir_q[13:11], 4'b0000};
            data_d   = ir_q[7:0];
            load_d   = 1'b1;
            ce_d     = 1'b1;
            state_d  = S_FETCH;
          end
          K_OP: begin
            opcode_d = ir_q[13:7];
            cin_d    = ir_q[1];
            cout_d   = ir_q[0];
            ce_d     = 1'b1;
            gap_d    = GAP_W'(OP_GAP);
            state_d  = S_GAP;
          end
          K_CTRL: begin
            if (ir_q[13]) begin
              // DJNZ: the 8-bit wrap makes cnt=0 loop 256 times.
              cnt_d = cnt_dec;
              if (cnt_dec != 8'd0) begin
                pc_d = ir_q[ADDR_W-1:0];
                jump = 1'b1;
              end
            end else begin
              cnt_d = ir_q[7:0];
            end
            state_d = S_FETCH;
          end
          default: begin
            state_d = S_DONE;
          end
        endcase
        // Falling off the last address still issues this word, then stops
        // the run with err set.
        if ((&pc_q) && kind != K_HALT && !jump) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_GAP: begin
        // The first GAP cycle is the OP's own ce cycle. OP_GAP idle cycles
        // follow, so OP issues are 3+OP_GAP cycles apart.
        if (gap_q == '0) begin
          state_d = S_FETCH;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o        = busy_q;
  assign done_o        = (state_q == S_DONE);
  assign err_o         = err_q;
  assign cpu_data_in_o = data_q;
  assign cpu_opcode_o  = opcode_q;
  assign cpu_cin_o     = cin_q;
  assign cpu_cout_o    = cout_q;
  assign cpu_load_o    = load_q;
  assign cpu_ce_o      = ce_q;

endmodule

// File: tb/tb_alu_program_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for alu_program_sequencer.
//
// Reference model: the model walks the program as instructions on a
// per-run timeline. Cycle 0 is the first cycle after the start edge.
// An instruction fetched at cycle t issues its command at t+2.
// The next fetch is at t+2 after LOAD/CTRL, or at t+3+OP_GAP after OP.
// Completion (HALT or overrun) gives done at t+2.
// This yields the expected per-cycle value of every output for the whole run.
// -----------------------------------------------------------------------------
module tb_alu_program_sequencer;
  localparam int ADDR_W = 5;
  localparam int OP_GAP = 1;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int MAXC   = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              prog_we_i;
  logic [ADDR_W-1:0] prog_addr_i;
  logic [15:0]       prog_wdata_i;
  logic              start_i;
  logic              busy_o, done_o, err_o;
  logic [7:0]        cpu_data_in_o;
  logic [6:0]        cpu_opcode_o;
  logic              cpu_cin_o, cpu_cout_o, cpu_load_o, cpu_ce_o;

  always #5 clk = ~clk;

  alu_program_sequencer #(.ADDR_W(ADDR_W), .OP_GAP(OP_GAP)) dut (
    .clk           (clk),
    .rst           (rst),
    .prog_we_i     (prog_we_i),
    .prog_addr_i   (prog_addr_i),
    .prog_wdata_i  (prog_wdata_i),
    .start_i       (start_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .cpu_data_in_o (cpu_data_in_o),
    .cpu_opcode_o  (cpu_opcode_o),
    .cpu_cin_o     (cpu_cin_o),
    .cpu_cout_o    (cpu_cout_o),
    .cpu_load_o    (cpu_load_o),
    .cpu_ce_o      (cpu_ce_o)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Word layout: {busy, done, err, ce, load, cin, cout, opcode[6:0], data[7:0]}
  logic [15:0] prog  [DEPTH];
  logic [21:0] exp_v [MAXC];
  int          exp_len;
  int          done_cyc;
  int          model_cnt;
  int          pend_cnt;

  function automatic logic [21:0] observed();
    return {busy_o, done_o, err_o, cpu_ce_o, cpu_load_o, cpu_cin_o, cpu_cout_o,
            cpu_opcode_o, cpu_data_in_o};
  endfunction

  task automatic check(input string tag, input int cyc, input logic [21:0] expv);
    logic [21:0] obs;
    obs = observed();
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s cyc %0d observed %h expected %h", tag, cyc, obs, expv);
    end
  endtask

  function automatic bit build_model();
    int          t;
    int          pc;
    int          cnt;
    int          nt;
    int          d;
    bit          halted;
    bit          jumped;
    logic [15:0] ir;
    t   = 0;
    pc  = 0;
    cnt = model_cnt;
    for (int c = 0; c < MAXC; c++) exp_v[c] = {1'b1, 21'b0};
    forever begin
      if (t + 6 + OP_GAP >= MAXC) return 1'b0;
      ir     = prog[pc];
      nt     = t + 2;
      halted = 1'b0;
      jumped = 1'b0;
      case (ir[15:14])
        2'b00: exp_v[t+2] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                             ir[13:11], 4'b0000, ir[7:0]};
        2'b01: begin
          exp_v[t+2] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ir[1], ir[0], ir[13:7], 8'h00};
          nt = t + 3 + OP_GAP;
        end
        2'b10: begin
          if (ir[13]) begin
            cnt = (cnt == 0) ? 255 : cnt - 1;
            if (cnt != 0) jumped = 1'b1;
          end else begin
            cnt = int'(ir[7:0]);
          end
        end
        default: halted = 1'b1;
      endcase
      if (halted || (pc == DEPTH - 1 && !jumped)) begin
        d = t + 2;
        exp_v[d][20] = 1'b1;
        for (int c = d; c < d + 3; c++) begin
          if (!halted) exp_v[c][19] = 1'b1;
          if (c > d)   exp_v[c][21] = 1'b0;
        end
        done_cyc = d;
        exp_len  = d + 3;
        pend_cnt = cnt;
        return 1'b1;
      end
      pc = jumped ? int'(ir[ADDR_W-1:0]) : pc + 1;
      t  = nt;
    end
  endfunction

  task automatic fill_halt();
    for (int i = 0; i < DEPTH; i++) prog[i] = 16'hC000;
  endtask

  task automatic load_prog();
    for (int a = 0; a < DEPTH; a++) begin
      @(posedge clk); #1;
      prog_we_i    = 1'b1;
      prog_addr_i  = ADDR_W'(a);
      prog_wdata_i = prog[a];
    end
    @(posedge clk); #1;
    prog_we_i = 1'b0;
  endtask

  // Starts a run and checks every output on every cycle of it.
  // inject: while busy, drive random start/prog_we traffic (must be ignored).
  // wr0:    write w0 to address 0 in the same cycle as start.
  task automatic run_check(input string tag, input bit inject, input bit wr0,
                           input logic [15:0] w0);
    if (wr0) prog[0] = w0;
    if (!build_model()) begin
      vectors++;
      miscompares++;
      $error("FAIL %s model did not terminate observed 0 expected 1", tag);
      return;
    end
    @(posedge clk); #1;
    start_i = 1'b1;
    if (wr0) begin
      prog_we_i    = 1'b1;
      prog_addr_i  = '0;
      prog_wdata_i = w0;
    end
    @(posedge clk); #1;
    start_i   = 1'b0;
    prog_we_i = 1'b0;
    for (int c = 0; c < exp_len; c++) begin
      @(negedge clk);
      check(tag, c, exp_v[c]);
      if (inject && c < done_cyc) begin
        start_i      = 1'($urandom);
        prog_we_i    = 1'($urandom);
        prog_addr_i  = ADDR_W'($urandom);
        prog_wdata_i = 16'($urandom);
      end else begin
        start_i   = 1'b0;
        prog_we_i = 1'b0;
      end
    end
    model_cnt = pend_cnt;
  endtask

  // Starts a run, checks up to stop_cyc, then asserts rst while ce is high.
  task automatic run_reset(input string tag, input int stop_cyc);
    void'(build_model());
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 0; c <= stop_cyc; c++) begin
      @(negedge clk);
      check(tag, c, exp_v[c]);
    end
    rst = 1'b1;
    #1;
    check({tag, "_rst"}, stop_cyc, 22'h0);
    @(negedge clk);
    rst       = 1'b0;
    model_cnt = 0;
  endtask

  task automatic gen_random(input bit with_ctrl);
    int          r;
    logic [13:0] r14;
    for (int i = 0; i < DEPTH; i++) begin
      r   = with_ctrl ? $urandom_range(0, 99) : $urandom_range(0, 69);
      r14 = 14'($urandom);
      if (r < 35)      prog[i] = {2'b00, r14};
      else if (r < 70) prog[i] = {2'b01, r14};
      else if (r < 85) prog[i] = {2'b10, r14};
      else             prog[i] = {2'b11, r14};
    end
  endtask

  initial begin
    bit ok;
    rst          = 1'b1;
    prog_we_i    = 1'b0;
    prog_addr_i  = '0;
    prog_wdata_i = '0;
    start_i      = 1'b0;
    model_cnt    = 0;
    #2;
    check("reset", 0, 22'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic program: LOAD r1,05; LOAD r0,03; OP sel1 op2; HALT.
    fill_halt();
    prog[0] = 16'h0805;
    prog[1] = 16'h0003;
    prog[2] = 16'h4900;
    prog[3] = 16'hC000;
    load_prog();
    run_check("basic", 1'b0, 1'b0, 16'h0);

    // Reset while ce is high (cycle 2). The program must survive the reset.
    run_reset("midrun", 2);
    run_check("after_rst", 1'b0, 1'b0, 16'h0);

    // start and prog_we are ignored while busy, and memory is not changed.
    run_check("busy_inject", 1'b1, 1'b0, 16'h0);
    run_check("post_inject", 1'b0, 1'b0, 16'h0);

    // A write to address 0 in the start cycle is seen by the first fetch.
    run_check("wr_start", 1'b0, 1'b1, 16'h28A5);

    // Back-to-back OPs.
    fill_halt();
    prog[0] = 16'h5182;
    prog[1] = 16'h6281;
    load_prog();
    run_check("op_op", 1'b0, 1'b0, 16'h0);

    // Counted loop: SETCNT 3; OP; DJNZ->1; HALT gives three OPs.
    fill_halt();
    prog[0] = 16'h8003;
    prog[1] = 16'h4900;
    prog[2] = 16'hA001;
    load_prog();
    run_check("loop3", 1'b0, 1'b0, 16'h0);

    // SETCNT 0 wraps to 256 iterations.
    fill_halt();
    prog[0] = 16'h8000;
    prog[1] = 16'h1007;
    prog[2] = 16'hA001;
    load_prog();
    run_check("loop_wrap", 1'b0, 1'b0, 16'h0);

    // No HALT: overrun sets err. The next start clears it.
    gen_random(1'b0);
    load_prog();
    run_check("overrun", 1'b0, 1'b0, 16'h0);
    run_check("err_clear", 1'b0, 1'b0, 16'h0);

    // HALT exactly at the last address is a clean finish.
    for (int i = 0; i < DEPTH; i++) prog[i] = 16'h0000 | 16'(i);
    prog[DEPTH-1] = 16'hC000;
    load_prog();
    run_check("halt_last", 1'b0, 1'b0, 16'h0);

    // Random programs.
    for (int n = 0; n < 10; n++) begin
      ok = 1'b0;
      for (int a = 0; a < 100 && !ok; a++) begin
        gen_random(1'b1);
        ok = build_model();
      end
      if (!ok) fill_halt();
      load_prog();
      run_check($sformatf("rand%0d", n), n[0], 1'b0, 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
